// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline hazard controller: forwarding selects,
// I-cache miss FSM encoding, default mul/div latencies and a register-match helper.
package pipe_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

  localparam logic [1:0] IC_IDLE   = 2'd0;
  localparam logic [1:0] IC_MISS   = 2'd1;
  localparam logic [1:0] IC_RESUME = 2'd2;

  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_DIV_LAT = 32;
  localparam int DEF_CNT_W   = 6;

  // r0 is hardwired zero, so a match on it never creates a dependency
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Occupancy counter for the iterative mul/div unit. Loads latency-1 on a start
// seen while idle and counts down to zero; busy while non-zero. Never stalled.
module md_busy_counter
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic div,
  output logic busy
);

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

  logic [CNT_W-1:0] count;

  // load on an idle start, otherwise drain; a start while busy is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (count == '0) begin
      if (start) count <= div ? DIV_LD : MUL_LD;
    end else
      count <= count - 1'b1;
  end

  assign busy = (count != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding selects, load-use,
// branch-operand and mul/div stalls, and the I-cache refill handshake FSM.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       branchD,
  input  logic       pcsrcD,
  input  logic       mdreadD,
  input  logic       mdstartD,
  input  logic       mdstartE,
  input  logic       mddivE,
  input  logic       imissF,
  input  logic       irdyF,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       icache_abort,
  output logic       mdbusy
);

  logic [1:0] state, state_nxt;
  logic       lwstall, brstall, mdstall, imiss;

  // EX-stage ALU bypass; MEM result is younger so it wins over WB
  always_comb begin
    forwardAE = FWD_RF;
    if (regwriteM && reg_match(rsE, writeregM))      forwardAE = FWD_MEM;
    else if (regwriteW && reg_match(rsE, writeregW)) forwardAE = FWD_WB;
    forwardBE = FWD_RF;
    if (regwriteM && reg_match(rtE, writeregM))      forwardBE = FWD_MEM;
    else if (regwriteW && reg_match(rtE, writeregW)) forwardBE = FWD_WB;
  end

  // ID-stage branch comparator bypass (only MEM is close enough to help)
  assign forwardAD = regwriteM && reg_match(rsD, writeregM);
  assign forwardBD = regwriteM && reg_match(rtD, writeregM);

  // load-use: value not available until the load leaves MEM
  assign lwstall = memtoregE && (reg_match(rsD, rtE) || reg_match(rtD, rtE));

  // branch compares in ID, so an ALU result in EX or a load in MEM is too late
  assign brstall = branchD &&
                   ((regwriteE && (reg_match(rsD, writeregE) || reg_match(rtD, writeregE))) ||
                    (memtoregM && (reg_match(rsD, writeregM) || reg_match(rtD, writeregM))));

  md_busy_counter #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT),
    .CNT_W  (CNT_W)
  ) u_md (
    .clk  (clk),
    .rst_n(rst_n),
    .start(mdstartE),
    .div  (mddivE),
    .busy (mdbusy)
  );

  // HI/LO readers and new mul/div ops wait for the unit to drain
  assign mdstall = mdbusy && (mdreadD || mdstartD);

  // I-cache refill FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IC_IDLE;
    else        state <= state_nxt;
  end

  // redirect during a miss abandons the refill; irdyF outside MISS is ignored
  always_comb begin
    state_nxt    = state;
    icache_abort = 1'b0;
    case (state)
      IC_IDLE:   if (imissF && !pcsrcD) state_nxt = IC_MISS;
      IC_MISS: begin
        if (pcsrcD) begin
          state_nxt    = IC_IDLE;
          icache_abort = 1'b1;
        end else if (irdyF)
          state_nxt = IC_RESUME;
      end
      IC_RESUME: state_nxt = IC_IDLE;
      default:   state_nxt = IC_IDLE;
    endcase
  end

  assign imiss = (state == IC_MISS) || ((state == IC_IDLE) && imissF);

  // a held ID stage inserts a bubble into EX; a redirect is only trusted when
  // ID is not stalled, since its operands may be stale
  always_comb begin
    stallD = lwstall || brstall || mdstall;
    stallF = stallD || imiss;
    flushE = stallD;
    flushD = !stallD && (pcsrcD || imiss);
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios plus random
// traffic; expected outputs come from a cycle-indexed reference model.
module tb_pipe_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic branchD, pcsrcD, mdreadD, mdstartD, mdstartE, mddivE, imissF, irdyF;
  logic stallF, stallD, flushD, flushE, forwardAD, forwardBD, icache_abort, mdbusy;
  logic [1:0] forwardAE, forwardBE;

  pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .pcsrcD(pcsrcD), .mdreadD(mdreadD), .mdstartD(mdstartD),
    .mdstartE(mdstartE), .mddivE(mddivE), .imissF(imissF), .irdyF(irdyF),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .icache_abort(icache_abort), .mdbusy(mdbusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sF, sD, fD, fE, aD, bD, ab, bz;
    logic [1:0] aE, bE;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0, n_total = 0;

  // reference model state: cycle number, end of mul/div occupancy, refill status
  int   cyc = 0;
  int   busy_end = 0;
  bit   miss_pending = 0, resume_slot = 0;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 0) && (a == b);
  endfunction

  function automatic exp_t model();
    exp_t e;
    bit lw, br, md, im, busy;
    e.aE = (regwriteM && hit(rsE, writeregM)) ? 2'd2 : (regwriteW && hit(rsE, writeregW)) ? 2'd1 : 2'd0;
    e.bE = (regwriteM && hit(rtE, writeregM)) ? 2'd2 : (regwriteW && hit(rtE, writeregW)) ? 2'd1 : 2'd0;
    e.aD = regwriteM && hit(rsD, writeregM);
    e.bD = regwriteM && hit(rtD, writeregM);
    lw = memtoregE && (hit(rsD, rtE) || hit(rtD, rtE));
    br = branchD && ((regwriteE && (hit(rsD, writeregE) || hit(rtD, writeregE))) ||
                     (memtoregM && (hit(rsD, writeregM) || hit(rtD, writeregM))));
    busy = cyc < busy_end;
    md = busy && (mdreadD || mdstartD);
    im = miss_pending || (!resume_slot && imissF);
    e.sD = lw || br || md;
    e.sF = e.sD || im;
    e.fE = e.sD;
    e.fD = !e.sD && (pcsrcD || im);
    e.ab = miss_pending && pcsrcD;
    e.bz = busy;
    return e;
  endfunction

  // push this cycle's expectation, then advance the model across the clock edge
  task automatic step();
    q.push_back(model());
    @(posedge clk);
    if (mdstartE && !(cyc < busy_end)) busy_end = cyc + (mddivE ? DIV_LAT : MUL_LAT);
    if (miss_pending) begin
      if (pcsrcD) miss_pending = 0;
      else if (irdyF) begin miss_pending = 0; resume_slot = 1; end
    end else if (resume_slot) resume_slot = 0;
    else if (imissF && !pcsrcD) miss_pending = 1;
    cyc++;
    #1;
  endtask

  task automatic clear_inputs();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
    {branchD, pcsrcD, mdreadD, mdstartD, mdstartE, mddivE, imissF, irdyF} = '0;
  endtask

  // monitor: the controller presents a full output set every cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("stallF", {1'b0, stallF}, {1'b0, e.sF});
        chk("stallD", {1'b0, stallD}, {1'b0, e.sD});
        chk("flushD", {1'b0, flushD}, {1'b0, e.fD});
        chk("flushE", {1'b0, flushE}, {1'b0, e.fE});
        chk("forwardAD", {1'b0, forwardAD}, {1'b0, e.aD});
        chk("forwardBD", {1'b0, forwardBD}, {1'b0, e.bD});
        chk("forwardAE", forwardAE, e.aE);
        chk("forwardBE", forwardBE, e.bE);
        chk("icache_abort", {1'b0, icache_abort}, {1'b0, e.ab});
        chk("mdbusy", {1'b0, mdbusy}, {1'b0, e.bz});
      end
    end
  end

  initial begin
    int n;
    clear_inputs();
    #12;
    chk("rst_stallF", {1'b0, stallF}, 2'd0);
    chk("rst_flushD", {1'b0, flushD}, 2'd0);
    chk("rst_mdbusy", {1'b0, mdbusy}, 2'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step();

    // EX forwarding, MEM beats WB
    regwriteM = 1; writeregM = 8; rsE = 8; regwriteW = 1; writeregW = 8;
    #1; chk("fwdAE_mem", forwardAE, 2'b10); step();
    writeregM = 0; rsE = 0; writeregW = 0;
    #1; chk("fwdAE_r0", forwardAE, 2'b00); step();
    clear_inputs();

    // load-use for exactly one cycle
    memtoregE = 1; rtE = 9; rsD = 9;
    #1; chk("lw_stall", {stallF, stallD}, 2'b11); step();
    clear_inputs();
    #1; chk("lw_release", {1'b0, stallD}, 2'd0); step();

    // branch operand in EX, then in MEM as an ALU result
    branchD = 1; regwriteE = 1; writeregE = 4; rtD = 4;
    #1; chk("br_stall", {1'b0, stallD}, 2'd1); step();
    regwriteE = 0; writeregE = 0; regwriteM = 1; writeregM = 4;
    #1; chk("br_fwd", {stallD, forwardBD}, 2'b01); step();
    clear_inputs();

    // divide then MFHI held in ID
    mdstartE = 1; mddivE = 1;
    #1; step();
    mdstartE = 0; mddivE = 0; mdreadD = 1;
    n = 0;
    for (int i = 0; i < 40; i++) begin #1; if (stallD) n++; step(); end
    n_total++;
    if (n == DIV_LAT - 1) n_pass++;
    else $display("FAIL div_stall_len: got %0d expected %0d", n, DIV_LAT - 1);
    clear_inputs();

    // I-cache miss through refill and resume slot
    imissF = 1;
    #1; chk("miss_flushD_stallF", {flushD, stallF}, 2'b11); step();
    imissF = 0;
    for (int i = 0; i < 3; i++) begin #1; chk("miss_hold", {1'b0, stallF}, 2'd1); step(); end
    irdyF = 1; #1; step();
    irdyF = 0; #1; chk("resume_no_stall", {1'b0, stallF}, 2'd0); step();
    #1; step();

    // redirect during a miss aborts the refill
    imissF = 1; #1; step();
    imissF = 0; pcsrcD = 1;
    #1; chk("abort", {1'b0, icache_abort}, 2'd1); step();
    pcsrcD = 0;
    #1; chk("abort_idle", {icache_abort, stallF}, 2'b00); step();

    // async reset in the middle of a divide, off the clock edge
    mdstartE = 1; mddivE = 1; #1; step();
    mdstartE = 0; mddivE = 0; mdreadD = 1;
    for (int i = 0; i < 14; i++) begin #1; step(); end
    #3; rst_n = 1'b0;
    #1;
    chk("arst_mdbusy", {1'b0, mdbusy}, 2'd0);
    chk("arst_stalls", {stallF, stallD}, 2'b00);
    busy_end = 0; miss_pending = 0; resume_slot = 0;
    #2; rst_n = 1'b1;
    clear_inputs();
    @(posedge clk); #1;

    // random traffic on a narrow register range to force collisions
    for (int i = 0; i < 3000; i++) begin
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3)); writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom_range(0, 1)); regwriteM = 1'($urandom_range(0, 1));
      regwriteW = 1'($urandom_range(0, 1));
      memtoregE = ($urandom_range(0, 3) == 0); memtoregM = ($urandom_range(0, 3) == 0);
      branchD = ($urandom_range(0, 3) == 0); pcsrcD = ($urandom_range(0, 7) == 0);
      mdreadD = ($urandom_range(0, 3) == 0); mdstartD = ($urandom_range(0, 7) == 0);
      mdstartE = (cyc >= busy_end) && ($urandom_range(0, 19) == 0);
      mddivE = ($urandom_range(0, 3) == 0);
      imissF = ($urandom_range(0, 7) == 0); irdyF = ($urandom_range(0, 5) == 0);
      #1; step();
    end

    clear_inputs();
    @(negedge clk); @(negedge clk);
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
